// File: rtl/rns_error_poly_mapper.sv
// Error-polynomial to RNS residue mapper.
// Streams NUM_ERR small signed error coefficients per cycle from the error BRAM
// and writes their residues modulo each active q_i to the error-residue BRAM.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, num_mod,     run request (IDLE only); active modulus count and input
//   fmt_twos            format (0 sign-magnitude, 1 two's complement), latched
//   q_vec               moduli, q_i in bits [i*LOGQ +: LOGQ]
//   busy, done          run in progress / one-cycle completion pulse
//   err_rd_*            error BRAM read port (BRAM_RD_LAT cycle latency)
//   res_wr_*            residue write port, one write per cycle while streaming
module rns_error_poly_mapper #(
  parameter int unsigned N           = 8192,
  parameter int unsigned LOGN        = 13,
  parameter int unsigned LOGQ        = 54,
  parameter int unsigned NUM_MOD     = 4,
  parameter int unsigned LOGM        = 2,
  parameter int unsigned NUM_ERR     = 2,
  parameter int unsigned EBITS       = 6,
  parameter int unsigned BRAM_RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LOGM:0]            num_mod,
  input  logic                     fmt_twos,
  input  logic [NUM_MOD*LOGQ-1:0]  q_vec,
  output logic                     busy,
  output logic                     done,
  output logic [LOGN-1:0]          err_rd_addr,
  output logic                     err_rd_en,
  input  logic [NUM_ERR*EBITS-1:0] err_rd_data,
  output logic [LOGN-1:0]          res_wr_addr,
  output logic [LOGM-1:0]          res_wr_mod,
  output logic [NUM_ERR*LOGQ-1:0]  res_wr_data,
  output logic                     res_wr_en
);

  localparam int unsigned CW = (BRAM_RD_LAT > 1) ? $clog2(BRAM_RD_LAT) : 1;
  localparam logic [LOGN-1:0] ADDR_LAST = LOGN'(N - 1);
  localparam logic [LOGM:0]   NUM_MOD_L = (LOGM+1)'(NUM_MOD);
  localparam logic [CW-1:0]   DRAIN_LAST = CW'(BRAM_RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t          state_q, state_d;
  logic [LOGM:0]   nmod_q, nmod_d;
  logic            fmt_q, fmt_d;
  logic [LOGN-1:0] addr_d;
  logic [LOGM-1:0] m_q, m_d;
  logic            rd_en_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_d, done_d;
  logic            last_mod_c;

  // Read-side pipeline tracking each issued read until its data returns
  logic [BRAM_RD_LAT-1:0]           vld_q;
  logic [BRAM_RD_LAT-1:0][LOGN-1:0] paddr_q;
  logic [BRAM_RD_LAT-1:0][LOGM-1:0] pm_q;

  logic [LOGQ-1:0]         q_sel_c;
  logic [NUM_ERR*LOGQ-1:0] conv_c;

  // Residue of one coefficient; negative zero maps to 0, never to q
  function automatic logic [LOGQ-1:0] to_residue(input logic [EBITS-1:0] e,
                                                 input logic             twos,
                                                 input logic [LOGQ-1:0]  q);
    logic [EBITS-1:0] mag;
    if (!e[EBITS-1]) return LOGQ'(e);
    mag = twos ? EBITS'(-e) : {1'b0, e[EBITS-2:0]};
    if (mag == '0) return '0;
    return q - LOGQ'(mag);
  endfunction

  assign last_mod_c = ({1'b0, m_q} == nmod_q - (LOGM+1)'(1));

  // Next-state and issue-side sequencing
  always_comb begin
    state_d = state_q;
    nmod_d  = nmod_q;
    fmt_d   = fmt_q;
    addr_d  = err_rd_addr;
    m_d     = m_q;
    rd_en_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fmt_d  = fmt_twos;
          nmod_d = (num_mod > NUM_MOD_L) ? NUM_MOD_L : num_mod;
          addr_d = '0;
          m_d    = '0;
          cnt_d  = '0;
          if (num_mod == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RUN;
            rd_en_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (err_rd_addr == ADDR_LAST) begin
          addr_d = '0;
          if (last_mod_c) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            m_d     = m_q + LOGM'(1);
            rd_en_d = 1'b1;
          end
        end else begin
          addr_d  = err_rd_addr + LOGN'(1);
          rd_en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        // FIN coincides with the final write so done lands one cycle after it
        if (cnt_q == DRAIN_LAST) state_d = S_FIN;
        else                     cnt_d = cnt_q + CW'(1);
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_FIN);
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      nmod_q      <= '0;
      fmt_q       <= 1'b0;
      err_rd_addr <= '0;
      err_rd_en   <= 1'b0;
      m_q         <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      nmod_q      <= nmod_d;
      fmt_q       <= fmt_d;
      err_rd_addr <= addr_d;
      err_rd_en   <= rd_en_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Delay address/modulus alongside the BRAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      paddr_q <= '0;
      pm_q    <= '0;
    end else begin
      vld_q[0]   <= err_rd_en;
      paddr_q[0] <= err_rd_addr;
      pm_q[0]    <= m_q;
      for (int i = 1; i < int'(BRAM_RD_LAT); i++) begin
        vld_q[i]   <= vld_q[i-1];
        paddr_q[i] <= paddr_q[i-1];
        pm_q[i]    <= pm_q[i-1];
      end
    end
  end

  // Modulus chosen by the delayed index so pass boundaries stay aligned with data
  always_comb begin
    q_sel_c = '0;
    for (int i = 0; i < int'(NUM_MOD); i++) begin
      if (pm_q[BRAM_RD_LAT-1] == LOGM'(i)) q_sel_c = q_vec[i*LOGQ +: LOGQ];
    end
    conv_c = '0;
    for (int k = 0; k < int'(NUM_ERR); k++) begin
      conv_c[k*LOGQ +: LOGQ] = to_residue(err_rd_data[k*EBITS +: EBITS], fmt_q, q_sel_c);
    end
  end

  // Conversion register driving the residue write port
  always_ff @(posedge clk) begin
    if (rst) begin
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_wr_mod  <= '0;
      res_wr_data <= '0;
    end else begin
      res_wr_en   <= vld_q[BRAM_RD_LAT-1];
      res_wr_addr <= paddr_q[BRAM_RD_LAT-1];
      res_wr_mod  <= pm_q[BRAM_RD_LAT-1];
      res_wr_data <= conv_c;
    end
  end

endmodule
